// File: rtl/gf128_pkg.sv
// Shared constants and fold helpers for GF(2^128) reduction modulo x^128+x^7+x^2+x+1.
package gf128_pkg;

  localparam int GF_W   = 128;
  localparam int PROD_W = 256;
  localparam int HI_W   = 127;
  localparam int T_W    = 135;
  localparam int U_W    = 7;

  // Low tail of P(x): x^7 + x^2 + x + 1
  localparam logic [7:0] POLY_TAIL = 8'h87;

  // First fold: hi * (x^7+x^2+x+1), 135 bits wide.
  function automatic logic [T_W-1:0] fold_hi(input logic [HI_W-1:0] hi);
    logic [T_W-1:0] h;
    logic [T_W-1:0] t;
    h = {{(T_W-HI_W){1'b0}}, hi};
    t = '0;
    for (int k = 0; k < 8; k++)
      if (POLY_TAIL[k]) t = t ^ (h << k);
    return t;
  endfunction

  // Second fold: the 7 spill bits of the first fold, folded once more.
  function automatic logic [GF_W-1:0] fold_u(input logic [U_W-1:0] u);
    logic [GF_W-1:0] x;
    logic [GF_W-1:0] r;
    x = {{(GF_W-U_W){1'b0}}, u};
    r = '0;
    for (int k = 0; k < 8; k++)
      if (POLY_TAIL[k]) r = r ^ (x << k);
    return r;
  endfunction

endpackage

// File: rtl/gf128_out_fifo.sv
// Small output FIFO for reduced beats; head is zero while empty. Write and pop may share a cycle even when full.
module gf128_out_fifo
  import gf128_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  logic [GF_W-1:0] din_i,
  input  logic            pop_i,
  output logic [GF_W-1:0] dout_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [GF_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_cnt;
  logic            w_do_push, w_do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o    = (r_cnt == CW'(DEPTH));
  assign empty_o   = (r_cnt == '0);
  assign w_do_pop  = pop_i & ~empty_o;
  // A pop frees the slot the write lands in, so full+pop still accepts.
  assign w_do_push = push_i & (~full_o | w_do_pop);
  assign dout_o    = empty_o ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) r_wptr <= ptr_inc(r_wptr);
      if (w_do_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= din_i;
  end

endmodule

// File: rtl/gf128_reduce.sv
// Reduces a 256-bit carry-less product modulo P(x) into a buffered 128-bit result.
// GF128_REDUCE_PIPE2_EN splits the two folds across two registered stages.
module gf128_reduce
  import gf128_pkg::*;
#(
  parameter int OUT_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [PROD_W-1:0] product_i,
  input  logic              clr_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [GF_W-1:0]   result_o,
  output logic              overflow_o
);

`ifdef GF128_REDUCE_PIPE2_EN
  localparam int REDUCE_LAT = 2;
`else
  localparam int REDUCE_LAT = 1;
`endif

  logic [REDUCE_LAT:1] r_vld_pipe;
  logic [T_W-1:0]      w_t;
  logic [GF_W-1:0]     r_res;
  logic                w_full, w_empty, w_pop, w_push, w_drop;
  logic                r_overflow;
  logic                w_unused;

  assign w_unused = product_i[PROD_W-1];
  assign w_t      = fold_hi(product_i[PROD_W-2:GF_W]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
    end else begin
      for (int s = REDUCE_LAT; s > 1; s--) r_vld_pipe[s] <= r_vld_pipe[s-1];
      r_vld_pipe[1] <= valid_i;
    end
  end

`ifdef GF128_REDUCE_PIPE2_EN
  logic [GF_W-1:0] r_lo;
  logic [U_W-1:0]  r_u;

  always_ff @(posedge clk) begin
    if (valid_i) begin
      r_lo <= product_i[GF_W-1:0] ^ w_t[GF_W-1:0];
      r_u  <= w_t[T_W-1:GF_W];
    end
    if (r_vld_pipe[1]) r_res <= r_lo ^ fold_u(r_u);
  end
`else
  always_ff @(posedge clk) begin
    if (valid_i)
      r_res <= product_i[GF_W-1:0] ^ w_t[GF_W-1:0] ^ fold_u(w_t[T_W-1:GF_W]);
  end
`endif

  assign w_push = r_vld_pipe[REDUCE_LAT];
  assign w_pop  = valid_o & ready_i;
  assign w_drop = w_push & w_full & ~w_pop;

  gf128_out_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_push),
    .din_i   (r_res),
    .pop_i   (w_pop),
    .dout_o  (result_o),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign valid_o = ~w_empty;

  // A drop in the same cycle as clr_i wins, so no lost beat goes unreported.
  always_ff @(posedge clk) begin
    if (!rst_n) r_overflow <= 1'b0;
    else        r_overflow <= (r_overflow & ~clr_i) | w_drop;
  end

  assign overflow_o = r_overflow;

endmodule
